// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction cache controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default geometry, entry field positions, controller FSM states.
package bp_pkg;

  // Default cache geometry: 2048 entries of 16 bits.
  localparam int BP_ADDR_W = 11;
  localparam int BP_DATA_W = 16;

  // Entry layout: {valid, pc[12:11], target[12:0]}.
  localparam int ENT_VALID_BIT = 15;
  localparam int ENT_PC_HI_MSB = 14;
  localparam int ENT_PC_HI_LSB = 13;
  localparam int ENT_TGT_MSB   = 12;
  localparam int ENT_TGT_LSB   = 0;

  typedef enum logic [1:0] {
    START = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2
  } bp_state_e;

endpackage

// File: rtl/bp_upd_fifo.sv
// Ordered two-push / one-pop FIFO buffering predictor updates.
// Latency: 1 cycle push-to-head (registered storage, no bypass).
// Backpressure: free_cnt (post-pop) tells the producer how many pushes fit; pushes beyond it are illegal.
// Ports: clk/rst_n, flush, push0_vld/dat (older), push1_vld/dat (younger),
//        pop_rdy, head_vld/head_dat, free_cnt.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push0_vld,
  input  logic [W-1:0]           push0_dat,
  input  logic                   push1_vld,
  input  logic [W-1:0]           push1_dat,
  input  logic                   pop_rdy,
  output logic                   head_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] free_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr1_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             pop;

  assign head_vld = (cnt != '0);
  assign head_dat = mem[rd_ptr];
  assign pop      = pop_rdy & head_vld;

  // Slots freed by this cycle's pop are usable by this cycle's pushes.
  assign free_cnt = CNT_W'(DEPTH) - cnt + CNT_W'(pop);

  // Lane 1 lands behind lane 0 when both push; alone it takes the tail slot.
  assign wr1_ptr = wr_ptr + PTR_W'(push0_vld);

  always_ff @(posedge clk) begin
    if (push0_vld) mem[wr_ptr]  <= push0_dat;
    if (push1_vld) mem[wr1_ptr] <= push1_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push0_vld) + PTR_W'(push1_vld);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      cnt    <= cnt + CNT_W'(push0_vld) + CNT_W'(push1_vld) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/bp_cache_ctrl.sv
// Branch-prediction cache controller: table clear, update buffering, single RAM port arbitration.
// Latency: lookup 0 cycles to RAM port; update >=1 cycle (through FIFO).
// Backpressure: lookups always win the port; updates that find the FIFO full are dropped and counted.
// Ports: clk/rst_n; upd0_*/upd1_*/kill1 from execute; rd_en/rd_addr from fetch; bp_clear;
//        ram_en/ram_we/ram_addr/ram_wdata to the cache RAM; init_busy, drop_cnt status.
module bp_cache_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = BP_ADDR_W,
  parameter int DATA_W = BP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd0_wen,
  input  logic [ADDR_W-1:0] upd0_addr,
  input  logic [DATA_W-1:0] upd0_data,
  input  logic              upd1_wen,
  input  logic [ADDR_W-1:0] upd1_addr,
  input  logic [DATA_W-1:0] upd1_data,
  input  logic              kill1,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              bp_clear,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              init_busy,
  output logic [7:0]        drop_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  bp_state_e         state;
  bp_state_e         state_nxt;
  logic [ADDR_W-1:0] init_idx;

  logic              fifo_head_vld;
  logic [ENT_W-1:0]  fifo_head_dat;
  logic [CNT_W-1:0]  fifo_free;
  logic              fifo_pop;

  logic              upd0_vld;
  logic              upd1_vld;
  logic              acc0;
  logic              acc1;
  logic              drop0;
  logic              drop1;
  logic [8:0]        drop_sum;

  // A killed lane 1 update never existed as far as the table is concerned.
  assign upd0_vld = upd0_wen;
  assign upd1_vld = upd1_wen & ~kill1;

  // Lane 0 claims the first free slot; lane 1 needs one more beyond it.
  assign acc0 = upd0_vld & (fifo_free != '0);
  assign acc1 = upd1_vld & (fifo_free > CNT_W'(acc0));

  // Updates arriving with a clear are discarded outright, not counted as drops.
  assign drop0 = upd0_vld & ~acc0 & ~bp_clear;
  assign drop1 = upd1_vld & ~acc1 & ~bp_clear;

  bp_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bp_clear),
    .push0_vld (acc0 & ~bp_clear),
    .push0_dat ({upd0_addr, upd0_data}),
    .push1_vld (acc1 & ~bp_clear),
    .push1_dat ({upd1_addr, upd1_data}),
    .pop_rdy   (fifo_pop),
    .head_vld  (fifo_head_vld),
    .head_dat  (fifo_head_dat),
    .free_cnt  (fifo_free)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= START;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter idles at 0 outside INIT and wraps back to 0 on the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx <= '0;
    end else if (bp_clear || (state != INIT)) begin
      init_idx <= '0;
    end else begin
      init_idx <= init_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    fifo_pop  = 1'b0;
    unique case (state)
      START: begin
        state_nxt = INIT;
      end
      INIT: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = init_idx;
        if (&init_idx) state_nxt = RUN;
      end
      RUN: begin
        if (rd_en) begin
          ram_en   = 1'b1;
          ram_addr = rd_addr;
        end else if (fifo_head_vld) begin
          fifo_pop  = 1'b1;
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = fifo_head_dat[ENT_W-1:DATA_W];
          ram_wdata = fifo_head_dat[DATA_W-1:0];
        end
      end
      default: begin
        state_nxt = START;
      end
    endcase
    if (bp_clear) state_nxt = INIT;
  end

  assign init_busy = (state != RUN);

  assign drop_sum = {1'b0, drop_cnt} + {8'd0, drop0} + {8'd0, drop1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule
